// File: rtl/led_frame_sched.sv
// Frame-level scheduler for the LED strip: refresh cadence, loader en/start sequencing,
// completion tracking, strip latch gap, and frame/skip/timeout reporting.
module led_frame_sched #(
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned GAP_CYCLES     = 15000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_enable,
    input  logic             repeat_en,
    input  logic             stat_valid,
    input  logic             send_start,
    input  logic             phy_done,
    input  logic             err_clr,
    output logic             fifo_en,
    output logic             fifo_start,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             timeout_err
);

    localparam int unsigned TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StArm,
        StKick,
        StWaitLoad,
        StWaitPhy,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             err_q, err_d;
    logic             fifo_en_q, fifo_start_q, busy_q;
    logic             tick;
    logic             skip_inc;
    logic             frame_inc;
    logic             to_set;

    // Refresh timer free-runs only while enabled; the wrap cycle is the tick.
    always_comb begin
        tick  = ctrl_enable && (tmr_q == TMR_LAST);
        tmr_d = tmr_q + 1'b1;
        if (!ctrl_enable || tick) begin
            tmr_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        gap_d     = '0;
        skip_inc  = 1'b0;
        frame_inc = 1'b0;
        to_set    = 1'b0;

        case (state_q)
            StIdle: begin
                if (ctrl_enable) begin
                    state_d = StWaitTick;
                end
            end
            StWaitTick: begin
                if (!ctrl_enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (pend_q || repeat_en) begin
                        state_d = StArm;
                    end else begin
                        skip_inc = 1'b1;
                    end
                end
            end
            StArm: begin
                state_d = StKick;
            end
            StKick: begin
                to_d    = '0;
                state_d = StWaitLoad;
            end
            StWaitLoad: begin
                if (send_start) begin
                    to_d    = '0;
                    state_d = StWaitPhy;
                end else if (to_q == TO_LAST) begin
                    to_set  = 1'b1;
                    state_d = StGap;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StWaitPhy: begin
                if (phy_done) begin
                    frame_inc = 1'b1;
                    state_d   = StGap;
                end else if (to_q == TO_LAST) begin
                    to_set  = 1'b1;
                    state_d = StGap;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ctrl_enable ? StWaitTick : StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A tick while a frame is in flight is dropped, not queued.
        if (tick && (state_q != StIdle) && (state_q != StWaitTick)) begin
            skip_inc = 1'b1;
        end
    end

    always_comb begin
        pend_d  = stat_valid || (pend_q && (state_q != StArm));
        frame_d = frame_q + {{(CNT_W-1){1'b0}}, frame_inc};
        skip_d  = skip_q + {{(CNT_W-1){1'b0}}, skip_inc};
        err_d   = to_set || (err_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            to_q         <= '0;
            gap_q        <= '0;
            pend_q       <= 1'b0;
            frame_q      <= '0;
            skip_q       <= '0;
            err_q        <= 1'b0;
            fifo_en_q    <= 1'b0;
            fifo_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            to_q         <= to_d;
            gap_q        <= gap_d;
            pend_q       <= pend_d;
            frame_q      <= frame_d;
            skip_q       <= skip_d;
            err_q        <= err_d;
            fifo_en_q    <= (state_q == StArm);
            fifo_start_q <= (state_q == StKick);
            busy_q       <= (state_d != StIdle) && (state_d != StWaitTick);
        end
    end

    assign fifo_en     = fifo_en_q;
    assign fifo_start  = fifo_start_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_q;
    assign skip_cnt    = skip_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched: two instances differing only in timeout length,
// driven from shared stimulus.
module tb_led_frame_sched;

    logic        clk;
    logic        rst;
    logic        ctrl_enable;
    logic        repeat_en;
    logic        stat_valid;
    logic        send_start;
    logic        phy_done;
    logic        err_clr;

    logic        fifo_en_a, fifo_start_a, busy_a, err_a;
    logic [15:0] frame_a, skip_a;
    logic        fifo_en_b, fifo_start_b, busy_b, err_b;
    logic [15:0] frame_b, skip_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_base;
    int          en_cnt_a = 0;

    led_frame_sched #(
        .REFRESH_CYCLES(100),
        .TIMEOUT_CYCLES(200),
        .GAP_CYCLES    (10),
        .CNT_W         (16)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .ctrl_enable(ctrl_enable),
        .repeat_en  (repeat_en),
        .stat_valid (stat_valid),
        .send_start (send_start),
        .phy_done   (phy_done),
        .err_clr    (err_clr),
        .fifo_en    (fifo_en_a),
        .fifo_start (fifo_start_a),
        .busy       (busy_a),
        .frame_cnt  (frame_a),
        .skip_cnt   (skip_a),
        .timeout_err(err_a)
    );

    led_frame_sched #(
        .REFRESH_CYCLES(100),
        .TIMEOUT_CYCLES(64),
        .GAP_CYCLES    (10),
        .CNT_W         (16)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ctrl_enable(ctrl_enable),
        .repeat_en  (repeat_en),
        .stat_valid (stat_valid),
        .send_start (send_start),
        .phy_done   (phy_done),
        .err_clr    (err_clr),
        .fifo_en    (fifo_en_b),
        .fifo_start (fifo_start_b),
        .busy       (busy_b),
        .frame_cnt  (frame_b),
        .skip_cnt   (skip_b),
        .timeout_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_en_a) en_cnt_a <= en_cnt_a + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        ctrl_enable = 1'b0;
        repeat_en   = 1'b0;
        stat_valid  = 1'b0;
        send_start  = 1'b0;
        phy_done    = 1'b0;
        err_clr     = 1'b0;
        step();
        step();
        step();
        check("rst_fifo_en", fifo_en_a, 0);
        check("rst_fifo_start", fifo_start_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_frame", frame_a, 0);
        check("rst_skip", skip_a, 0);
        check("rst_err", err_a, 0);

        // Basic frame; the e200 tick lands in WAIT_PHY, the e300 tick finds stale data.
        rst = 1'b0;
        ctrl_enable = 1'b1;
        cyc = 0;
        goto(4);   stat_valid = 1'b1;
        goto(5);   stat_valid = 1'b0;
        goto(100); check("basic_en_early", fifo_en_a, 0);
                   check("basic_arm_busy", busy_a, 1);
        goto(101); check("basic_en", fifo_en_a, 1);
                   check("basic_start_early", fifo_start_a, 0);
        goto(102); check("basic_en_fall", fifo_en_a, 0);
                   check("basic_start", fifo_start_a, 1);
        goto(151); send_start = 1'b1;
        goto(152); send_start = 1'b0;
        goto(199); check("basic_skip0", skip_a, 0);
        goto(200); check("basic_overrun", skip_a, 1);
        goto(231); phy_done = 1'b1;
        goto(232); phy_done = 1'b0;
                   check("basic_frame", frame_a, 1);
                   check("basic_gap_busy", busy_a, 1);
        goto(241); check("basic_gap_end_busy", busy_a, 1);
        goto(242); check("basic_idle", busy_a, 0);
                   check("basic_err", err_a, 0);
        goto(300); check("basic_stale_skip", skip_a, 2);

        // Stale skip
        do_reset();
        en_base = en_cnt_a;
        goto(300); check("stale_skip3", skip_a, 3);
                   check("stale_no_en", en_cnt_a - en_base, 0);
        repeat_en = 1'b1;
        goto(400); check("stale_en_early", fifo_en_a, 0);
        goto(401); check("stale_repeat_en", fifo_en_a, 1);
                   check("stale_skip_hold", skip_a, 3);

        // Overrun
        do_reset();
        en_base = en_cnt_a;
        goto(109); send_start = 1'b1;
        goto(110); send_start = 1'b0;
        goto(199); check("ovr_skip0", skip_a, 0);
        goto(200); check("ovr_skip1", skip_a, 1);
        goto(259); phy_done = 1'b1;
        goto(260); phy_done = 1'b0;
                   check("ovr_frame", frame_a, 1);
        goto(270); check("ovr_idle", busy_a, 0);
        goto(300); check("ovr_no_early_en", fifo_en_a, 0);
        goto(301); check("ovr_next_en", fifo_en_a, 1);
                   check("ovr_en_count", en_cnt_a - en_base, 1);
                   check("ovr_skip_final", skip_a, 1);

        // Timeout on the 64-cycle instance
        do_reset();
        goto(165); check("to_err_early", err_b, 0);
        goto(166); check("to_err", err_b, 1);
                   check("to_gap_busy", busy_b, 1);
        goto(176); check("to_gap_done", busy_b, 0);
                   check("to_frame", frame_b, 0);
        goto(179); err_clr = 1'b1;
        goto(180); err_clr = 1'b0;
                   check("to_clr", err_b, 0);
        goto(265); err_clr = 1'b1;
        goto(266); err_clr = 1'b0;
                   check("to_set_wins", err_b, 1);
                   check("to_skip", skip_b, 0);

        // Disable mid-frame
        do_reset();
        repeat_en = 1'b0;
        en_base = en_cnt_a;
        goto(4);   stat_valid = 1'b1;
        goto(5);   stat_valid = 1'b0;
        goto(110); ctrl_enable = 1'b0;
        goto(119); send_start = 1'b1;
        goto(120); send_start = 1'b0;
        goto(149); phy_done = 1'b1;
        goto(150); phy_done = 1'b0;
                   check("dis_frame", frame_a, 1);
        goto(159); check("dis_gap_busy", busy_a, 1);
        goto(160); check("dis_idle", busy_a, 0);
        repeat_en = 1'b1;
        goto(500); check("dis_en_count", en_cnt_a - en_base, 1);
                   check("dis_still_idle", busy_a, 0);
                   check("dis_frame_hold", frame_a, 1);

        // Async reset during WAIT_PHY
        cyc = 0;
        ctrl_enable = 1'b1;
        goto(109); send_start = 1'b1;
        goto(110); send_start = 1'b0;
        goto(130); check("ar_busy_pre", busy_a, 1);
                   check("ar_frame_pre", frame_a, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_busy", busy_a, 0);
        check("ar_frame", frame_a, 0);
        check("ar_skip", skip_a, 0);
        check("ar_fifo_en", fifo_en_a, 0);
        check("ar_fifo_start", fifo_start_a, 0);
        check("ar_err", err_a, 0);
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        goto(100); check("ar_en_early", fifo_en_a, 0);
        goto(101); check("ar_first_en", fifo_en_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
